// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM states, redirect sources and reset/exception PCs.
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    WAIT_DRAIN = 2'd2
  } fetch_state_e;

  // Encoded so that a smaller non-zero value means a higher priority.
  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_EXC  = 2'd1,
    RS_BR   = 2'd2,
    RS_JMP  = 2'd3
  } redirect_src_e;

  function automatic logic outranks(input redirect_src_e a, input redirect_src_e b);
    return (a != RS_NONE) && ((b == RS_NONE) || (a < b));
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority redirect select (exception > branch > jump) with word-aligned target.
module redirect_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic            exception,
  input  logic            branch_hazard,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [1:0]      src,
  output logic [PC_W-1:0] target
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~{{(PC_W-2){1'b0}}, 2'b11};

  redirect_src_e   src_s;
  logic [PC_W-1:0] raw_s;

  // Priority select of the redirect source and its raw target.
  always_comb begin
    src_s = RS_NONE;
    raw_s = {PC_W{1'b0}};
    if (exception) begin
      src_s = RS_EXC;
      raw_s = EXC_VECTOR;
    end else if (branch_hazard) begin
      src_s = RS_BR;
      raw_s = branch_target;
    end else if (jump) begin
      src_s = RS_JMP;
      raw_s = jump_target;
    end else begin
      src_s = RS_NONE;
      raw_s = {PC_W{1'b0}};
    end
  end

  assign src    = src_s;
  assign target = raw_s & ALIGN_MASK;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage fetch PC, imem request handshake and redirect/flush control.
// Optional MIPS branch delay slot enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_redirect_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            BranchHazard,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  input  logic            Exception,
  input  logic            ImemReady,
  output logic            ImemReq,
  output logic [PC_W-1:0] ImemAddr,
  output logic [PC_W-1:0] IF_PC,
  output logic            IF_Valid,
  output logic            IF_Flush
);

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'b100};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pending_q, pending_d;
  logic [PC_W-1:0] pending_pc_q, pending_pc_d;
  redirect_src_e   pending_src_q, pending_src_d;
  logic            imem_req_q, imem_req_d;

  logic [1:0]      arb_src_s;
  logic [PC_W-1:0] arb_tgt_s;
  redirect_src_e   rs_s;
  logic            slot_s;
  logic            keep_s;
  logic            take_s;
  logic            if_valid_s;
  logic            if_flush_s;

  redirect_arbiter #(
    .PC_W       (PC_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .exception     (Exception),
    .branch_hazard (BranchHazard),
    .branch_target (BranchTarget),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .src           (arb_src_s),
    .target        (arb_tgt_s)
  );

  assign rs_s   = redirect_src_e'(arb_src_s);
  assign take_s = outranks(rs_s, pending_src_q);

`ifdef FETCH_DELAY_SLOT_EN
  // Branch/jump keep the word completing fetch as the delay slot; exceptions still kill it.
  assign slot_s = (rs_s == RS_BR) || (rs_s == RS_JMP);
  assign keep_s = (pending_src_q != RS_EXC);
`else
  assign slot_s = 1'b0;
  assign keep_s = 1'b0;
`endif

  // Next-state, PC and pending-redirect computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    pending_pc_d  = pending_pc_q;
    pending_src_d = pending_src_q;
    if_valid_s    = 1'b0;
    if_flush_s    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (rs_s != RS_NONE) begin
          if_flush_s = ~slot_s;
          if (ImemReady) begin
            pc_d       = arb_tgt_s;
            if_valid_s = slot_s;
          end else begin
            // The in-flight request is never aborted; remember where to go.
            pending_d     = 1'b1;
            pending_pc_d  = arb_tgt_s;
            pending_src_d = rs_s;
            state_d       = WAIT_DRAIN;
          end
        end else if (Stall) begin
          if_valid_s = 1'b0;
        end else if (ImemReady) begin
          if_valid_s = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      WAIT_DRAIN: begin
        if (take_s) begin
          if_flush_s    = ~slot_s;
          pending_pc_d  = arb_tgt_s;
          pending_src_d = rs_s;
        end else begin
          if_flush_s = 1'b0;
        end
        if (ImemReady) begin
          if (take_s) begin
            pc_d = arb_tgt_s;
          end else if (pending_q) begin
            pc_d = pending_pc_q;
          end else begin
            pc_d = pc_q;
          end
          if_valid_s    = keep_s && (!take_s || slot_s);
          pending_d     = 1'b0;
          pending_src_d = RS_NONE;
          state_d       = FETCH;
        end else begin
          state_d = WAIT_DRAIN;
        end
      end
      default: begin
        state_d       = BOOT;
        pending_d     = 1'b0;
        pending_src_d = RS_NONE;
      end
    endcase
    imem_req_d = (state_d != BOOT);
  end

  // State, PC and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      pending_pc_q  <= {PC_W{1'b0}};
      pending_src_q <= RS_NONE;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pending_pc_q  <= pending_pc_d;
      pending_src_q <= pending_src_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign ImemReq  = imem_req_q;
  assign ImemAddr = pc_q;
  assign IF_Valid = if_valid_s;
  assign IF_Flush = if_flush_s;
  assign IF_PC    = if_valid_s ? pc_q : {PC_W{1'b0}};

endmodule
